// File: rtl/sram_match_scheduler_if.sv
// ----------------------------------------------------------------------------
// sram_match_scheduler_if
// Bundles the frontend request side and the SRAM status/claim side of the
// match scheduler.
//   master : frontends/backends; drive requests and SRAM status, receive grants
//   slave  : the scheduler itself
// Signals
//   match_enable [NUM_PORT]          per-port request level
//   new_length   [NUM_PORT*9]        packet length in words, port p at [p*9 +: 9]
//   sram_free    [NUM_SRAM*FREE_W]   free words, SRAM s at [s*FREE_W +: FREE_W]
//   sram_busy    [NUM_SRAM]          SRAM owned by an in-flight packet
//   match_suc    [NUM_PORT]          one-hot one-cycle grant
//   match_sram   [SRAM_IDX_W]        chosen SRAM, valid while match_suc != 0
//   sram_claim   [NUM_SRAM]          one-hot claim pulse, coincident with match_suc
//   sched_busy   [1]                 scheduler FSM not idle
// ----------------------------------------------------------------------------
interface sram_match_scheduler_if #(
    parameter int unsigned NUM_PORT   = 16,
    parameter int unsigned NUM_SRAM   = 32,
    parameter int unsigned SRAM_IDX_W = 5,
    parameter int unsigned FREE_W     = 11
);
    logic [NUM_PORT-1:0]        match_enable;
    logic [NUM_PORT*9-1:0]      new_length;
    logic [NUM_SRAM*FREE_W-1:0] sram_free;
    logic [NUM_SRAM-1:0]        sram_busy;
    logic [NUM_PORT-1:0]        match_suc;
    logic [SRAM_IDX_W-1:0]      match_sram;
    logic [NUM_SRAM-1:0]        sram_claim;
    logic                       sched_busy;

    modport master (
        output match_enable,
        output new_length,
        output sram_free,
        output sram_busy,
        input  match_suc,
        input  match_sram,
        input  sram_claim,
        input  sched_busy
    );

    modport slave (
        input  match_enable,
        input  new_length,
        input  sram_free,
        input  sram_busy,
        output match_suc,
        output match_sram,
        output sram_claim,
        output sched_busy
    );
endinterface

// File: rtl/sram_match_scheduler.sv
// ----------------------------------------------------------------------------
// sram_match_scheduler
// Binds each new packet from the port write frontends to one of NUM_SRAM
// shared SRAMs. Requests are arbitrated round-robin; SRAMs are scanned one per
// cycle from a rotating start index, looking for a non-busy SRAM with enough
// free words. The winner gets a one-cycle match_suc with the SRAM index, and the
// SRAM backend gets a coincident sram_claim pulse.
// Ports
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : sram_match_scheduler_if.slave (requests, SRAM status, grants)
// ----------------------------------------------------------------------------
module sram_match_scheduler #(
    parameter int unsigned NUM_PORT   = 16,
    parameter int unsigned NUM_SRAM   = 32,
    parameter int unsigned SRAM_IDX_W = 5,
    parameter int unsigned FREE_W     = 11
) (
    input logic                    clk,
    input logic                    rst_n,
    sram_match_scheduler_if.slave  bus
);
    localparam int unsigned PORT_IDX_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
    localparam int unsigned LEN_W      = 9;
    localparam int unsigned CMP_W      = FREE_W + LEN_W;

    typedef enum logic [1:0] {StIdle, StScan, StGrant, StCool} state_e;

    state_e                  state_q, state_d;
    logic [PORT_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SRAM_IDX_W-1:0]   sram_ptr_q, sram_ptr_d;
    logic [SRAM_IDX_W-1:0]   scan_idx_q, scan_idx_d;
    logic [SRAM_IDX_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [PORT_IDX_W-1:0]   cur_port_q, cur_port_d;
    logic [LEN_W-1:0]        cur_len_q, cur_len_d;
    logic [NUM_PORT-1:0]     match_suc_q, match_suc_d;
    logic [SRAM_IDX_W-1:0]   match_sram_q, match_sram_d;
    logic [NUM_SRAM-1:0]     sram_claim_q, sram_claim_d;

    logic                    pick_valid;
    logic [PORT_IDX_W-1:0]   pick_port;
    logic [FREE_W-1:0]       free_cur;
    logic                    eligible;
    logic [SRAM_IDX_W-1:0]   scan_idx_inc;
    logic [PORT_IDX_W-1:0]   cur_port_inc;

    // Round-robin pick: first requester at or after rr_ptr, wrapping modulo NUM_PORT.
    always_comb begin : p_pick
        int unsigned cand;
        cand       = 0;
        pick_valid = 1'b0;
        pick_port  = '0;
        for (int unsigned i = 0; i < NUM_PORT; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= NUM_PORT) begin
                cand = cand - NUM_PORT;
            end
            if (!pick_valid && bus.match_enable[cand]) begin
                pick_valid = 1'b1;
                pick_port  = PORT_IDX_W'(cand);
            end
        end
    end

    // Busy and free are sampled live; cur_len is the length frozen at pick time.
    always_comb begin
        free_cur = bus.sram_free[scan_idx_q*FREE_W +: FREE_W];
        eligible = !bus.sram_busy[scan_idx_q] && (CMP_W'(free_cur) >= CMP_W'(cur_len_q));
    end

    // Plain modulo increments; counts need not be powers of two.
    always_comb begin
        scan_idx_inc = (scan_idx_q == SRAM_IDX_W'(NUM_SRAM - 1)) ? '0 : scan_idx_q + 1'b1;
        cur_port_inc = (cur_port_q == PORT_IDX_W'(NUM_PORT - 1)) ? '0 : cur_port_q + 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        sram_ptr_d   = sram_ptr_q;
        scan_idx_d   = scan_idx_q;
        scan_cnt_d   = scan_cnt_q;
        cur_port_d   = cur_port_q;
        cur_len_d    = cur_len_q;
        // Outputs are pulses: zero unless the GRANT state sets them.
        match_suc_d  = '0;
        match_sram_d = '0;
        sram_claim_d = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    cur_port_d = pick_port;
                    cur_len_d  = bus.new_length[pick_port*LEN_W +: LEN_W];
                    scan_idx_d = sram_ptr_q;
                    scan_cnt_d = '0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                if (!bus.match_enable[cur_port_q]) begin
                    // Withdrawal wins over eligibility; pointers stay put.
                    state_d = StIdle;
                end else if (eligible) begin
                    // scan_idx_q is held and serves as the found index in GRANT.
                    state_d = StGrant;
                end else if (scan_cnt_q == SRAM_IDX_W'(NUM_SRAM - 1)) begin
                    // Full sweep failed: give the next port a turn.
                    state_d  = StIdle;
                    rr_ptr_d = cur_port_inc;
                end else begin
                    scan_idx_d = scan_idx_inc;
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            StGrant: begin
                match_suc_d[cur_port_q]  = 1'b1;
                match_sram_d             = scan_idx_q;
                sram_claim_d[scan_idx_q] = 1'b1;
                rr_ptr_d                 = cur_port_inc;
                sram_ptr_d               = scan_idx_inc;
                state_d                  = StCool;
            end
            StCool: begin
                // Gives the frontend time to drop its request and the backend to go busy.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            sram_ptr_q   <= '0;
            scan_idx_q   <= '0;
            scan_cnt_q   <= '0;
            cur_port_q   <= '0;
            cur_len_q    <= '0;
            match_suc_q  <= '0;
            match_sram_q <= '0;
            sram_claim_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            sram_ptr_q   <= sram_ptr_d;
            scan_idx_q   <= scan_idx_d;
            scan_cnt_q   <= scan_cnt_d;
            cur_port_q   <= cur_port_d;
            cur_len_q    <= cur_len_d;
            match_suc_q  <= match_suc_d;
            match_sram_q <= match_sram_d;
            sram_claim_q <= sram_claim_d;
        end
    end

    assign bus.match_suc  = match_suc_q;
    assign bus.match_sram = match_sram_q;
    assign bus.sram_claim = sram_claim_q;
    assign bus.sched_busy = (state_q != StIdle);

endmodule

// File: tb/tb_sram_match_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sram_match_scheduler
// Directed bench for sram_match_scheduler. Inputs change and outputs are
// sampled on the falling clock edge. Latencies are counted in falling edges
// from the one on which a request is raised: a grant visible after rising
// edge E0+k is seen at count k+1.
// ----------------------------------------------------------------------------
module tb_sram_match_scheduler;
    localparam int unsigned NUM_PORT   = 16;
    localparam int unsigned NUM_SRAM   = 32;
    localparam int unsigned SRAM_IDX_W = 5;
    localparam int unsigned FREE_W     = 11;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    sram_match_scheduler_if #(
        .NUM_PORT  (NUM_PORT),
        .NUM_SRAM  (NUM_SRAM),
        .SRAM_IDX_W(SRAM_IDX_W),
        .FREE_W    (FREE_W)
    ) bus ();

    sram_match_scheduler #(
        .NUM_PORT  (NUM_PORT),
        .NUM_SRAM  (NUM_SRAM),
        .SRAM_IDX_W(SRAM_IDX_W),
        .FREE_W    (FREE_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: observed no end of run, required $finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_all_free(input int unsigned v);
        for (int s = 0; s < NUM_SRAM; s++) begin
            bus.sram_free[s*FREE_W +: FREE_W] = FREE_W'(v);
        end
    endtask

    // Bounded poll for a grant; returns the number of falling edges consumed.
    task automatic wait_grant(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.match_suc == '0 && cyc < max_cyc);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Single-port request: check latency and grant, drop request, check pulse ends.
    task automatic do_grant(input int port, input int len, input int exp_sram,
                            input int exp_cyc, input string tag);
        int cyc;
        logic [63:0] one;
        one = 64'd1;
        bus.new_length[port*9 +: 9] = 9'(len);
        bus.match_enable[port] = 1'b1;
        wait_grant(40, cyc);
        check({tag, "_lat"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_suc"}, 64'(bus.match_suc), one << port);
        check({tag, "_sram"}, 64'(bus.match_sram), 64'(exp_sram));
        check({tag, "_claim"}, 64'(bus.sram_claim), one << exp_sram);
        bus.match_enable[port] = 1'b0;
        tick(1);
        check({tag, "_clr"}, 64'(bus.match_suc), 64'd0);
    endtask

    initial begin : main
        int          cyc;
        logic [15:0] seen;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.match_enable = '0;
        bus.new_length   = '0;
        bus.sram_busy    = '0;
        set_all_free(2047);

        // Reset state
        tick(2);
        check("rst_suc", 64'(bus.match_suc), 64'd0);
        check("rst_sram", 64'(bus.match_sram), 64'd0);
        check("rst_claim", 64'(bus.sram_claim), 64'd0);
        check("rst_busy", 64'(bus.sched_busy), 64'd0);
        rst_n = 1'b1;
        tick(1);

        // Single request, then a follow-up takes the next SRAM
        do_grant(3, 40, 0, 3, "single");
        do_grant(3, 40, 1, 3, "single_next");

        // Simultaneous requests from rr_ptr=0: grants 2,5,9 spaced 4 cycles
        do_reset();
        bus.new_length[2*9 +: 9] = 9'd20;
        bus.new_length[5*9 +: 9] = 9'd20;
        bus.new_length[9*9 +: 9] = 9'd20;
        bus.match_enable = 16'h0224;
        wait_grant(40, cyc);
        check("multi0_lat", 64'(cyc), 64'd3);
        check("multi0_suc", 64'(bus.match_suc), 64'h0004);
        check("multi0_sram", 64'(bus.match_sram), 64'd0);
        bus.match_enable[2] = 1'b0;
        wait_grant(40, cyc);
        check("multi1_gap", 64'(cyc), 64'd4);
        check("multi1_suc", 64'(bus.match_suc), 64'h0020);
        check("multi1_sram", 64'(bus.match_sram), 64'd1);
        bus.match_enable[5] = 1'b0;
        wait_grant(40, cyc);
        check("multi2_gap", 64'(cyc), 64'd4);
        check("multi2_suc", 64'(bus.match_suc), 64'h0200);
        check("multi2_sram", 64'(bus.match_sram), 64'd2);
        bus.match_enable[9] = 1'b0;
        tick(1);

        // SRAMs 0-4 busy: grant SRAM 5 seven cycles after the request edge
        do_reset();
        bus.sram_busy = 32'h0000_001F;
        do_grant(0, 10, 5, 8, "busy_skip");
        bus.sram_busy = '0;
        // now rr_ptr=1, sram_ptr=6

        // Nothing fits port 1: full sweep, rr_ptr=2, pending port 4 wins on SRAM 6
        set_all_free(100);
        bus.new_length[1*9 +: 9] = 9'd300;
        bus.new_length[4*9 +: 9] = 9'd10;
        bus.match_enable = 16'h0012;
        seen = '0;
        repeat (32) begin
            @(negedge clk);
            seen = seen | bus.match_suc;
        end
        check("sweep_nogrant", 64'(seen), 64'd0);
        check("sweep_busy_hi", 64'(bus.sched_busy), 64'd1);
        tick(1);
        check("sweep_idle", 64'(bus.sched_busy), 64'd0);
        wait_grant(40, cyc);
        check("sweep_next_lat", 64'(cyc), 64'd3);
        check("sweep_next_suc", 64'(bus.match_suc), 64'h0010);
        check("sweep_next_sram", 64'(bus.match_sram), 64'd6);
        bus.match_enable = '0;
        tick(1);
        set_all_free(2047);
        // now rr_ptr=5, sram_ptr=7

        // Port 6 withdraws in scan cycle 3 while SRAMs 7-16 are busy
        bus.sram_busy = 32'h0001_FF80;
        bus.new_length[6*9 +: 9] = 9'd20;
        bus.match_enable[6] = 1'b1;
        tick(4);
        check("wd_scanning", 64'(bus.sched_busy), 64'd1);
        bus.match_enable[6] = 1'b0;
        tick(1);
        check("wd_idle", 64'(bus.sched_busy), 64'd0);
        check("wd_nosuc", 64'(bus.match_suc), 64'd0);
        bus.sram_busy = '0;
        do_grant(6, 20, 7, 3, "wd_ptr_kept");

        // Reset while scanning
        bus.sram_busy = '1;
        bus.new_length[0*9 +: 9] = 9'd5;
        bus.match_enable[0] = 1'b1;
        tick(3);
        check("rscan_busy", 64'(bus.sched_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rscan_sched", 64'(bus.sched_busy), 64'd0);
        check("rscan_suc", 64'(bus.match_suc), 64'd0);
        check("rscan_claim", 64'(bus.sram_claim), 64'd0);
        bus.match_enable[0] = 1'b0;
        bus.sram_busy = '0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        do_grant(0, 5, 0, 3, "post_reset");

        // Reset while the grant pulse is out clears it at once
        bus.new_length[2*9 +: 9] = 9'd5;
        bus.match_enable[2] = 1'b1;
        wait_grant(40, cyc);
        check("rgrant_suc_on", 64'(bus.match_suc), 64'h0004);
        rst_n = 1'b0;
        #1;
        check("rgrant_suc", 64'(bus.match_suc), 64'd0);
        check("rgrant_sram", 64'(bus.match_sram), 64'd0);
        check("rgrant_claim", 64'(bus.sram_claim), 64'd0);
        check("rgrant_sched", 64'(bus.sched_busy), 64'd0);
        bus.match_enable[2] = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        // now rr_ptr=0, sram_ptr=0

        // Zero length fits an SRAM with no free words
        set_all_free(0);
        do_grant(7, 0, 0, 3, "len_zero");

        // Exact fit: SRAM 1 one word short, SRAM 2 exactly enough
        set_all_free(39);
        bus.sram_free[2*FREE_W +: FREE_W] = 11'd40;
        do_grant(8, 40, 2, 4, "exact_fit");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
